// File: rtl/uart_rx.sv
// UART receiver: 2-FF synchronised serial input, 16x-style oversampled
// mid-bit sampling, optional parity, one stop bit, break detection.
module uart_rx #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 arst_n,
  input  logic                 rx_clk_en,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int unsigned OSW = $clog2(OVERSAMPLE);
  localparam int unsigned BCW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [OSW-1:0] OS_HALF = OSW'(OVERSAMPLE / 2 - 1);
  localparam logic [OSW-1:0] OS_LAST = OSW'(OVERSAMPLE - 1);
  localparam logic [BCW-1:0] BC_LAST = BCW'(DATA_BITS - 1);
  localparam logic           PAR_ODD = 1'(PARITY_ODD);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } state_t;

  state_t               state;
  logic [1:0]           sync;
  logic                 rx_s;
  logic [OSW-1:0]       os_cnt;
  logic [BCW-1:0]       bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;

  // Synchroniser resets to the idle (high) line level
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) sync <= 2'b11;
    else         sync <= {sync[0], rx};
  end

  assign rx_s = sync[1];

  // Frame FSM; advances only on oversample ticks, pulses clear every clk
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state      <= IDLE;
      os_cnt     <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      if (rx_clk_en) begin
        case (state)
          IDLE: begin
            if (!rx_s) begin
              state  <= START;
              os_cnt <= '0;
              busy   <= 1'b1;
            end
          end
          START: begin
            if (os_cnt == OS_HALF) begin
              if (rx_s) begin
                state <= IDLE;
                busy  <= 1'b0;
              end else begin
                os_cnt  <= '0;
                bit_cnt <= '0;
                state   <= DATA;
              end
            end else begin
              os_cnt <= os_cnt + 1'b1;
            end
          end
          DATA: begin
            if (os_cnt == OS_LAST) begin
              shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
              os_cnt  <= '0;
              bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt == BC_LAST) state <= (PARITY_EN != 0) ? PARITY : STOP;
            end else begin
              os_cnt <= os_cnt + 1'b1;
            end
          end
          PARITY: begin
            if (os_cnt == OS_LAST) begin
              par_bit <= rx_s;
              os_cnt  <= '0;
              state   <= STOP;
            end else begin
              os_cnt <= os_cnt + 1'b1;
            end
          end
          STOP: begin
            if (os_cnt == OS_LAST) begin
              os_cnt <= '0;
              if (rx_s) begin
                data_out   <= shreg;
                data_valid <= 1'b1;
                parity_err <= (PARITY_EN != 0) && (par_bit ^ (^shreg) ^ PAR_ODD);
                state      <= IDLE;
                busy       <= 1'b0;
              end else begin
                frame_err <= 1'b1;
                state     <= BREAK;
              end
            end else begin
              os_cnt <= os_cnt + 1'b1;
            end
          end
          BREAK: begin
            // One frame_err per held-low line; wait for it to return high
            if (rx_s) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: an 8N1 instance and an 8E1 instance, directed frames
// followed by random frames checked against a frame-level reference model.
module tb_uart_rx;

  localparam int OS = 16;

  logic       clk = 1'b0;
  logic       arst_n = 1'b0;
  logic       en_gate = 1'b1;
  logic [1:0] div = 2'd0;
  logic       rx_clk_en;
  logic       rx_n = 1'b1, rx_p = 1'b1;
  logic [7:0] dout_n, dout_p;
  logic       dv_n, pe_n, fe_n, busy_n;
  logic       dv_p, pe_p, fe_p, busy_p;

  int ncmp = 0;
  int nfail = 0;

  logic [9:0] q_n[$];
  logic [9:0] q_p[$];
  int fe_cnt_n = 0, fe_cnt_p = 0;
  int rd_n = 0, rd_p = 0, fe_seen_n = 0, fe_seen_p = 0;
  logic [7:0] exp_last [2];

  always #5 clk = ~clk;
  always @(posedge clk) div <= div + 2'd1;
  assign rx_clk_en = en_gate && (div == 2'd3);

  uart_rx #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY_EN(0), .PARITY_ODD(0)) dut_n (
    .clk(clk), .arst_n(arst_n), .rx_clk_en(rx_clk_en), .rx(rx_n),
    .data_out(dout_n), .data_valid(dv_n), .parity_err(pe_n), .frame_err(fe_n), .busy(busy_n));

  uart_rx #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY_EN(1), .PARITY_ODD(0)) dut_p (
    .clk(clk), .arst_n(arst_n), .rx_clk_en(rx_clk_en), .rx(rx_p),
    .data_out(dout_p), .data_valid(dv_p), .parity_err(pe_p), .frame_err(fe_p), .busy(busy_p));

  // Record each delivered word as {busy, parity_err, data}
  always @(negedge clk) begin
    if (dv_n) q_n.push_back({busy_n, pe_n, dout_n});
    if (dv_p) q_p.push_back({busy_p, pe_p, dout_p});
    if (fe_n) fe_cnt_n <= fe_cnt_n + 1;
    if (fe_p) fe_cnt_p <= fe_cnt_p + 1;
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: run did not complete within time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      do @(posedge clk); while (rx_clk_en !== 1'b1);
    end
    #1;
  endtask

  task automatic drive(input bit sel, input logic b, input int nt);
    if (sel) rx_p = b;
    else     rx_n = b;
    wait_ticks(nt);
  endtask

  task automatic send_frame(input bit sel, input logic [7:0] d, input logic pbit,
                            input logic stop, input int slen);
    drive(sel, 1'b0, OS);
    for (int i = 0; i < 8; i++) drive(sel, d[i], OS);
    if (sel) drive(sel, pbit, OS);
    drive(sel, stop, OS * slen);
    if (sel) rx_p = 1'b1;
    else     rx_n = 1'b1;
  endtask

  // Reference: even parity is violated when data plus parity bit hold an odd count of ones
  function automatic logic model_perr(input bit sel, input logic [7:0] d, input logic pbit);
    int ones;
    if (!sel) return 1'b0;
    ones = int'(pbit);
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    return (ones % 2) != 0;
  endfunction

  task automatic expect_rx(input string tag, input bit sel, input int nvalid,
                           input logic [7:0] d, input logic pe, input int nfe);
    int avail, fe;
    logic [9:0] e;
    avail = sel ? (q_p.size() - rd_p) : (q_n.size() - rd_n);
    chk({tag, ".valid_cnt"}, avail, nvalid);
    if (nvalid > 0 && avail > 0) begin
      if (sel) begin e = q_p[rd_p]; rd_p++; end
      else     begin e = q_n[rd_n]; rd_n++; end
      chk({tag, ".data"}, e[7:0], d);
      chk({tag, ".parity_err"}, e[8], pe);
      chk({tag, ".busy_at_valid"}, e[9], 1'b0);
      exp_last[sel] = d;
    end
    fe = sel ? (fe_cnt_p - fe_seen_p) : (fe_cnt_n - fe_seen_n);
    chk({tag, ".frame_err_cnt"}, fe, nfe);
    if (sel) fe_seen_p = fe_cnt_p;
    else     fe_seen_n = fe_cnt_n;
    chk({tag, ".data_out_held"}, sel ? dout_p : dout_n, exp_last[sel]);
  endtask

  task automatic run_frame(input string tag, input bit sel, input logic [7:0] d,
                           input logic pbit, input logic stop, input int slen);
    send_frame(sel, d, pbit, stop, slen);
    if (stop) begin
      expect_rx(tag, sel, 1, d, model_perr(sel, d, pbit), 0);
      chk({tag, ".busy_end"}, sel ? busy_p : busy_n, 1'b0);
    end else begin
      expect_rx(tag, sel, 0, 8'h00, 1'b0, 1);
      chk({tag, ".busy_break"}, sel ? busy_p : busy_n, 1'b1);
      wait_ticks(2);
      chk({tag, ".busy_after_break"}, sel ? busy_p : busy_n, 1'b0);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".data_out_n"}, dout_n, 8'h00);
    chk({tag, ".busy_n"}, busy_n, 1'b0);
    chk({tag, ".flags_n"}, {dv_n, pe_n, fe_n}, 3'b000);
    chk({tag, ".data_out_p"}, dout_p, 8'h00);
    chk({tag, ".busy_p"}, busy_p, 1'b0);
  endtask

  initial begin
    logic [7:0] d;
    logic       pb, st;
    bit         sel;
    int         avail;
    exp_last[0] = 8'h00;
    exp_last[1] = 8'h00;

    // Reset state
    repeat (5) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    arst_n = 1'b1;
    wait_ticks(4);

    // 8N1 frame 0xA5
    run_frame("t1_a5", 0, 8'hA5, 1'b0, 1'b1, 1);
    wait_ticks(OS);

    // Stop bit held low for three bit times: one frame_err, data_out keeps 0xA5
    run_frame("t3_break", 0, 8'h3C, 1'b0, 1'b0, 3);
    wait_ticks(OS);

    // False start: low for four ticks only
    drive(0, 1'b0, 4);
    chk("t2_glitch.busy_high", busy_n, 1'b1);
    drive(0, 1'b1, OS);
    chk("t2_glitch.busy_low", busy_n, 1'b0);
    expect_rx("t2_glitch", 0, 0, 8'h00, 1'b0, 0);
    run_frame("t2_3c", 0, 8'h3C, 1'b0, 1'b1, 1);
    wait_ticks(OS);

    // Even parity: correct then wrong parity bit
    run_frame("t4_par_ok", 1, 8'h07, 1'b1, 1'b1, 1);
    wait_ticks(OS);
    run_frame("t4_par_bad", 1, 8'h07, 1'b0, 1'b1, 1);
    wait_ticks(OS);

    // Back-to-back frames with no idle time
    run_frame("t5_55", 0, 8'h55, 1'b0, 1'b1, 1);
    run_frame("t5_aa", 0, 8'hAA, 1'b0, 1'b1, 1);
    wait_ticks(OS);

    // Reset after data bit 3 of 0xFF
    drive(0, 1'b0, OS);
    for (int i = 0; i < 4; i++) drive(0, 1'b1, OS);
    arst_n = 1'b0;
    #2;
    exp_last[0] = 8'h00;
    exp_last[1] = 8'h00;
    chk_reset_outputs("t6_midreset");
    rx_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    arst_n = 1'b1;
    wait_ticks(OS);
    expect_rx("t6_after_reset", 0, 0, 8'h00, 1'b0, 0);

    // 0x81 with rx_clk_en gated low after data bit 2
    d = 8'h81;
    drive(0, 1'b0, OS);
    for (int i = 0; i < 3; i++) drive(0, d[i], OS);
    en_gate = 1'b0;
    repeat (60) @(posedge clk);
    #1;
    chk("t6_gate.busy_frozen", busy_n, 1'b1);
    avail = q_n.size() - rd_n;
    chk("t6_gate.no_valid", avail, 0);
    en_gate = 1'b1;
    for (int i = 3; i < 8; i++) drive(0, d[i], OS);
    drive(0, 1'b1, OS);
    expect_rx("t6_81", 0, 1, 8'h81, 1'b0, 0);
    wait_ticks(OS);

    // Random frames on both instances
    for (int k = 0; k < 24; k++) begin
      sel = 1'($urandom_range(0, 1));
      d   = 8'($urandom);
      pb  = 1'($urandom_range(0, 1));
      st  = ($urandom_range(0, 5) != 0);
      run_frame($sformatf("rnd%0d", k), sel, d, pb, st, st ? 1 : int'($urandom_range(1, 2)));
      wait_ticks(OS * int'($urandom_range(0, 2)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
